// File: rtl/x3_pkg.sv
// x3_pkg: constants and small helpers shared by the serial excess-3 encoder
// and decoder.
//   X3_OFFSET  excess-3 bias, also the bit-serial subtrahend pattern (0011)
//   X3_MIN/MAX legal excess-3 code range
//   BCD_MAX    largest legal BCD digit
//   bitpos_t   position of the current serial bit within a digit
package x3_pkg;

    localparam int unsigned BIDX_W = 2;

    localparam logic [3:0] X3_OFFSET = 4'd3;
    localparam logic [3:0] X3_MIN    = 4'd3;
    localparam logic [3:0] X3_MAX    = 4'd12;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic [BIDX_W-1:0] {
        BIT0 = 2'd0,
        BIT1 = 2'd1,
        BIT2 = 2'd2,
        BIT3 = 2'd3
    } bitpos_t;

    // Next serial bit position; BIT3 wraps to BIT0 for the following digit.
    function automatic bitpos_t next_bit(input bitpos_t p);
        bitpos_t n;
        unique case (p)
            BIT0:    n = BIT1;
            BIT1:    n = BIT2;
            BIT2:    n = BIT3;
            default: n = BIT0;
        endcase
        return n;
    endfunction

    // Bit of the excess-3 bias that is subtracted at serial position p.
    function automatic logic offset_bit(input bitpos_t p);
        logic b;
        unique case (p)
            BIT0:    b = X3_OFFSET[0];
            BIT1:    b = X3_OFFSET[1];
            BIT2:    b = X3_OFFSET[2];
            default: b = X3_OFFSET[3];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/x3_bitsub.sv
// x3_bitsub: bit-serial subtract stage of the excess-3 decoder.
// Subtracts the excess-3 bias from an LSB-first serial stream, one bit per
// enabled cycle, and reports each completed 4-bit result.
//   clk, rst  clock, synchronous active-high reset
//   en        in carries a valid bit this cycle
//   restart   treat this cycle as bit 0 (with en) or clear framing (without)
//   in        serial excess-3 bit
//   d         difference bit for the current input bit
//   done      this bit completes a digit
//   digit     completed digit value (valid with done), code - 3 mod 16
//   illegal   completed code outside the legal excess-3 range (with done)
module x3_bitsub
    import x3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    input  logic       in,
    output logic       d,
    output logic       done,
    output logic [3:0] digit,
    output logic       illegal
);

    bitpos_t    bidx;
    bitpos_t    bidx_eff;
    logic       borrow;
    logic       bin;
    logic       sub;
    logic       bout;
    // Only the three low result bits need storage; bit 3 is the live d.
    logic [2:0] shreg;

    always_comb begin
        bidx_eff = restart ? BIT0 : bidx;
        bin      = (bidx_eff == BIT0) ? 1'b0 : borrow;
        sub      = offset_bit(bidx_eff);
        d        = in ^ sub ^ bin;
        bout     = (~in & sub) | (~in & bin) | (sub & bin);
        done     = en && (bidx_eff == BIT3);
        digit    = {d, shreg};
        // A final borrow means code < 3; a result above 9 means code > 12.
        illegal  = bout || (digit > BCD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bidx   <= BIT0;
            borrow <= 1'b0;
            shreg  <= '0;
        end else if (en) begin
            unique case (bidx_eff)
                BIT0:    shreg[0] <= d;
                BIT1:    shreg[1] <= d;
                BIT2:    shreg[2] <= d;
                default: ;
            endcase
            borrow <= bout;
            bidx   <= next_bit(bidx_eff);
        end else if (restart) begin
            bidx   <= BIT0;
            borrow <= 1'b0;
            shreg  <= '0;
        end
    end

endmodule

// File: rtl/serx3tobcd.sv
// serx3tobcd: serial excess-3 to BCD converter.
// Receives excess-3 digits LSB first, one bit per valid cycle, and returns
// the BCD stream with one cycle of latency, each completed digit, and an
// assembled DIGITS-digit word with error flags for illegal codes.
//   clk, rst             clock, synchronous active-high reset
//   inval, in            serial excess-3 bit and its valid
//   sync                 framing realign (bit 0 of digit 0 when with inval)
//   out, outval          registered serial BCD bit and its valid
//   bcd_digit            last completed digit
//   digit_val, digit_err digit completion pulse and illegal-code flag
//   bcd_word             assembled word, first received digit in [3:0]
//   word_val, word_err   word completion pulse and OR of digit errors
module serx3tobcd
    import x3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inval,
    input  logic                in,
    input  logic                sync,
    output logic                out,
    output logic                outval,
    output logic [3:0]          bcd_digit,
    output logic                digit_val,
    output logic                digit_err,
    output logic [4*DIGITS-1:0] bcd_word,
    output logic                word_val,
    output logic                word_err
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);

    logic          d;
    logic          done;
    logic [3:0]    digit;
    logic          illegal;

    logic [DW-1:0] didx;
    logic [DW-1:0] didx_eff;
    logic          sticky;
    logic          sticky_eff;
    logic          word_done;
    logic          err_acc;

    x3_bitsub u_bitsub (
        .clk     (clk),
        .rst     (rst),
        .en      (inval),
        .restart (sync),
        .in      (in),
        .d       (d),
        .done    (done),
        .digit   (digit),
        .illegal (illegal)
    );

    // sync discards the partial word before the current bit is processed.
    always_comb begin
        didx_eff   = sync ? '0 : didx;
        sticky_eff = sync ? 1'b0 : sticky;
        word_done  = done && (didx_eff == LAST);
        err_acc    = sticky_eff | illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= 1'b0;
            outval    <= 1'b0;
            bcd_digit <= '0;
            digit_val <= 1'b0;
            digit_err <= 1'b0;
            bcd_word  <= '0;
            word_val  <= 1'b0;
            word_err  <= 1'b0;
            didx      <= '0;
            sticky    <= 1'b0;
        end else begin
            outval    <= inval;
            digit_val <= done;
            digit_err <= done & illegal;
            word_val  <= word_done;
            word_err  <= word_done & err_acc;

            if (inval) begin
                out <= d;
            end

            if (done) begin
                bcd_digit <= digit;
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    if (didx_eff == DW'(k)) begin
                        bcd_word[4*k +: 4] <= digit;
                    end
                end
                if (word_done) begin
                    didx   <= '0;
                    sticky <= 1'b0;
                end else begin
                    didx   <= didx_eff + 1'b1;
                    sticky <= err_acc;
                end
            end else if (sync) begin
                didx   <= '0;
                sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serx3tobcd.sv
// tb_serx3tobcd: self-checking bench for serx3tobcd (DIGITS = 4).
// A digit-level arithmetic model predicts every output each cycle; directed
// sequences add hand-computed literal expectations.
module tb_serx3tobcd;

    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                inval;
    logic                in;
    logic                sync;
    logic                out;
    logic                outval;
    logic [3:0]          bcd_digit;
    logic                digit_val;
    logic                digit_err;
    logic [4*DIGITS-1:0] bcd_word;
    logic                word_val;
    logic                word_err;

    serx3tobcd #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .inval     (inval),
        .in        (in),
        .sync      (sync),
        .out       (out),
        .outval    (outval),
        .bcd_digit (bcd_digit),
        .digit_val (digit_val),
        .digit_err (digit_err),
        .bcd_word  (bcd_word),
        .word_val  (word_val),
        .word_err  (word_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Model state: position in digit, partial code value, digit slot.
    int unsigned m_pos;
    int unsigned m_code;
    int unsigned m_dig;
    logic        m_sticky;
    logic [3:0]  m_word [DIGITS];

    logic                e_out, e_outval, e_dv, e_de, e_wv, e_we;
    logic [3:0]          e_digit;
    logic [4*DIGITS-1:0] e_word;

    logic cap_out [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pos = 0; m_code = 0; m_dig = 0; m_sticky = 1'b0;
        for (int i = 0; i < DIGITS; i++) m_word[i] = 4'h0;
        e_out = 0; e_outval = 0; e_dv = 0; e_de = 0; e_wv = 0; e_we = 0;
        e_digit = 4'h0; e_word = '0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic b, input logic s);
        int unsigned val;
        logic        err;
        if (r) begin
            model_reset();
            return;
        end
        e_outval = v;
        e_dv = 0; e_de = 0; e_wv = 0; e_we = 0;
        if (s) begin
            m_pos = 0; m_code = 0; m_dig = 0; m_sticky = 1'b0;
        end
        if (v) begin
            m_code = m_code + (int'(b) << m_pos);
            // Bit k of (code - 3) depends only on code bits 0..k.
            e_out = ((m_code + 16 - 3) >> m_pos) & 1;
            if (m_pos == 3) begin
                val = (m_code + 16 - 3) % 16;
                err = (m_code < 3) || (m_code > 12);
                e_digit = 4'(val);
                e_dv = 1; e_de = err;
                m_word[m_dig] = 4'(val);
                m_sticky = m_sticky | err;
                if (m_dig == DIGITS - 1) begin
                    e_wv = 1; e_we = m_sticky;
                    m_dig = 0; m_sticky = 1'b0;
                end else begin
                    m_dig++;
                end
                m_pos = 0; m_code = 0;
            end else begin
                m_pos++;
            end
        end
        for (int i = 0; i < DIGITS; i++) e_word[4*i +: 4] = m_word[i];
    endtask

    task automatic compare_all();
        check("out",       out,       e_out);
        check("outval",    outval,    e_outval);
        check("bcd_digit", bcd_digit, e_digit);
        check("digit_val", digit_val, e_dv);
        check("digit_err", digit_err, e_de);
        check("bcd_word",  bcd_word,  e_word);
        check("word_val",  word_val,  e_wv);
        check("word_err",  word_err,  e_we);
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic s);
        rst = r; inval = v; in = b; sync = s;
        model_step(r, v, b, s);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic send_code(input logic [3:0] code, input int gap, input logic sync_first);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, code[i], sync_first && (i == 0));
            cap_out[i] = out;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                    check("gap_outval", outval, 0);
                end
            end
        end
    endtask

    task automatic check_digit(input string name, input logic [3:0] v, input logic e);
        check({name, "_val"}, digit_val, 1);
        check({name, "_digit"}, bcd_digit, v);
        check({name, "_err"}, digit_err, e);
    endtask

    initial begin
        model_reset();
        rst = 1; inval = 0; in = 0; sync = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_word", bcd_word, 0);
        check("rst_outval", outval, 0);
        check("rst_digit", bcd_digit, 0);

        // x3 1000 -> BCD 5, serial 1,0,1,0
        send_code(4'b1000, 0, 1'b0);
        check("d5_out0", cap_out[0], 1);
        check("d5_out1", cap_out[1], 0);
        check("d5_out2", cap_out[2], 1);
        check("d5_out3", cap_out[3], 0);
        check_digit("d5", 4'h5, 1'b0);

        // Four clean digits assemble into 16'h4321.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_code(4'b0100, 0, 1'b0);
        send_code(4'b0101, 0, 1'b0);
        send_code(4'b0110, 0, 1'b0);
        send_code(4'b0111, 0, 1'b0);
        check("w_word", bcd_word, 16'h4321);
        check("w_val", word_val, 1);
        check("w_err", word_err, 0);

        // Illegal codes inside a word, then a clean word.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_code(4'b0001, 0, 1'b0);
        check_digit("ill1", 4'hE, 1'b1);
        send_code(4'b1101, 0, 1'b0);
        check_digit("ill13", 4'hA, 1'b1);
        send_code(4'b0011, 0, 1'b0);
        check_digit("x3_3", 4'h0, 1'b0);
        send_code(4'b1000, 0, 1'b0);
        check("ill_wval", word_val, 1);
        check("ill_werr", word_err, 1);
        send_code(4'd6, 0, 1'b0);
        send_code(4'd7, 0, 1'b0);
        send_code(4'd8, 0, 1'b0);
        send_code(4'd9, 0, 1'b0);
        check("clean_word", bcd_word, 16'h6543);
        check("clean_werr", word_err, 0);

        // Gapped input, 2 idle cycles between bits.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_code(4'b1100, 2, 1'b0);
        check_digit("gap9", 4'h9, 1'b0);

        // Two stray bits, then a sync-aligned digit.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        send_code(4'b0110, 0, 1'b1);
        check_digit("sync3", 4'h3, 1'b0);
        check("sync_slice0", {28'b0, bcd_word[3:0]}, 3);

        // Reset after 1.5 digits (bit in the reset cycle is dropped).
        send_code(4'd7, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("mrst_word", bcd_word, 0);
        check("mrst_out", out, 0);
        check("mrst_digit", bcd_digit, 0);
        send_code(4'd12, 0, 1'b0);
        send_code(4'd3, 0, 1'b0);
        send_code(4'd8, 0, 1'b0);
        send_code(4'd10, 0, 1'b0);
        check("mrst_word2", bcd_word, 16'h7509);
        check("mrst_wval", word_val, 1);

        // Randomized traffic with occasional sync and reset.
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
